// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide unit with architectural HI/LO.
// Multiply is radix-2 shift-add, divide is restoring shift-subtract; both run
// 32 single-bit iterations on operand magnitudes, then a FIX cycle applies the
// sign correction and commits the result to HI/LO.
// Build option: define MULDIV_DIV_EN to include the divide datapath and DIV
// state. Without it, DIV/DIVU starts are accepted as no-ops.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_FIX  = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  // Working pair: multiply keeps {partial product, multiplier};
  // divide keeps {partial remainder, dividend/quotient}.
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [31:0] r_opnd;
  // Negate the product / quotient in FIX.
  logic        r_neg_lo;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
`ifdef MULDIV_DIV_EN
  logic        r_is_div;
  logic        r_neg_hi;
  logic        r_div_zero;
`endif

  // Operand magnitudes: only the signed ops (op[0]==0) take absolute values.
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[31];
  assign w_b_neg  = w_signed & b[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
  assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;

  // One shift-add step: conditionally add the multiplicand, then shift the
  // 33-bit sum and the multiplier right together.
  logic [32:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'd0);

  // Sign-corrected product for the commit.
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_lo ? (64'd0 - w_prod) : w_prod;

`ifdef MULDIV_DIV_EN
  // One restoring step: shift the next dividend bit into the remainder and
  // try subtracting the divisor; a borrow means restore (keep the shift).
  logic [32:0] w_div_shift;
  logic [33:0] w_div_diff;
  logic        w_div_ok;
  assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
  assign w_div_ok    = ~w_div_diff[33];

  // Quotient follows sign(a)^sign(b); remainder follows the dividend sign.
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  assign w_quo_fix = r_neg_lo ? (32'd0 - r_acc_lo) : r_acc_lo;
  assign w_rem_fix = r_neg_hi ? (32'd0 - r_acc_hi) : r_acc_hi;
`endif

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= 5'd0;
      r_acc_hi   <= 32'd0;
      r_acc_lo   <= 32'd0;
      r_opnd     <= 32'd0;
      r_neg_lo   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
`ifdef MULDIV_DIV_EN
      r_is_div   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            // An accepted start always drops a same-cycle MTHI/MTLO.
            r_count <= 5'd0;
            if (op[1]) begin
`ifdef MULDIV_DIV_EN
              r_acc_hi   <= 32'd0;
              r_acc_lo   <= w_a_mag;
              r_opnd     <= w_b_mag;
              r_neg_lo   <= w_a_neg ^ w_b_neg;
              r_neg_hi   <= w_a_neg;
              r_div_zero <= (b == 32'd0);
              r_is_div   <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_DIV;
`endif
            end else begin
              r_acc_hi <= 32'd0;
              r_acc_lo <= w_b_mag;
              r_opnd   <= w_a_mag;
              r_neg_lo <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
              r_is_div <= 1'b0;
`endif
              r_busy   <= 1'b1;
              r_state  <= S_MUL;
            end
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_MUL: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc_hi <= w_mul_sum[32:1];
            r_acc_lo <= {w_mul_sum[0], r_acc_lo[31:1]};
            r_count  <= r_count + 5'd1;
            if (r_count == 5'd31) r_state <= S_FIX;
          end
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc_hi <= w_div_ok ? w_div_diff[31:0] : w_div_shift[31:0];
            r_acc_lo <= {r_acc_lo[30:0], w_div_ok};
            r_count  <= r_count + 5'd1;
            if (r_count == 5'd31) r_state <= S_FIX;
          end
        end
`endif
        S_FIX: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!flush) begin
            r_done <= 1'b1;
`ifdef MULDIV_DIV_EN
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= r_div_zero ? 32'hFFFF_FFFF : w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[63:32];
              r_lo <= w_prod_fix[31:0];
            end
`else
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
`endif
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic model.
// Expectations for DIV/DIVU follow the MULDIV_DIV_EN build option.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Architectural result {hi,lo} of one operation, straight from the arithmetic rules.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] ph,
                                        input logic [31:0] pl);
    logic [63:0] r;
    int sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'd0: r = 64'(longint'($signed(x)) * longint'($signed(y)));
      2'd1: r = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (!DIV_EN) r = {ph, pl};
        else if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (!DIV_EN) r = {ph, pl};
        else if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // Issue one op; optionally collide it with an MTHI/MTLO and poke start/writes mid-flight.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit with_wr, input bit poke);
    logic [63:0] exp;
    int n;
    bit saw;
    exp = model(o, x, y, m_hi, m_lo);
    start = 1'b1; op = o; a = x; b = y;
    if (with_wr) begin hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom; end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom;
    check("hold_hi", hi, m_hi);
    check("hold_lo", lo, m_lo);
    if (o[1] && !DIV_EN) begin
      saw = 1'b0;
      for (int i = 0; i < 36; i++) begin
        if (busy || done) saw = 1'b1;
        @(posedge clk); #1;
      end
      check("noop_quiet", saw, 1'b0);
      check("noop_hi", hi, m_hi);
      check("noop_lo", lo, m_lo);
      $display("op=%0d a=%h b=%h -> no-op hi=%h lo=%h", o, x, y, hi, lo);
      return;
    end
    check("busy_rise", busy, 1'b1);
    n = 0;
    while (!done && n < 60) begin
      if (poke && n == 5) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      n++;
      if (!done && !busy) break;
    end
    check("latency", 64'(n), 64'd33);
    check("res_hi", hi, exp[63:32]);
    check("res_lo", lo, exp[31:0]);
    check("busy_fall", busy, 1'b0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(posedge clk); #1;
    check("done_pulse", done, 1'b0);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", o, x, y, hi, lo, n);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    int sel;
    bit saw;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst = 1'b1;
    $display("reset released hi=%h lo=%h", hi, lo);

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1; hi_we = 1'b0;
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo", lo, 32'd0);
    m_hi = 32'h0000_1234;
    $display("mthi wdata=00001234 -> hi=%h", hi);
    lo_we = 1'b1; wdata = 32'hCAFE_0001;
    @(posedge clk); #1; lo_we = 1'b0;
    check("mtlo_lo", lo, 32'hCAFE_0001);
    m_lo = 32'hCAFE_0001;
    $display("mtlo wdata=cafe0001 -> lo=%h", lo);

    // Directed corner cases
    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'd2, 32'd8, 32'd2, 1'b1, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    run_op(2'd1, $urandom, $urandom, 1'b1, 1'b0);

    // Flush mid-multiply: abort, no done, HI/LO kept, next start accepted
    start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_done", done, 1'b0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);
    $display("flush mid MULT 5x6 -> busy=%0d hi=%h lo=%h", busy, hi, lo);
    run_op(2'd1, 32'd5, 32'd6, 1'b0, 1'b0);

    // Flush beats start in the same cycle
    start = 1'b1; flush = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("flush_start", busy, 1'b0);
    $display("start+flush -> busy=%0d", busy);

    // Reset mid-operation
    start = 1'b1; op = DIV_EN ? 2'd3 : 2'd1; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    #1; rst = 1'b0; start = 1'b1; hi_we = 1'b1; flush = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; rst = 1'b1; start = 1'b0; hi_we = 1'b0; flush = 1'b0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_hi", hi, 32'd0);
    check("mrst_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw = 1'b1;
      @(posedge clk); #1;
    end
    check("mrst_quiet", saw, 1'b0);
    $display("reset mid-op -> busy=%0d hi=%h lo=%h", busy, hi, lo);

    // MTHI after reset, then MTHI attempted while busy
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1; hi_we = 1'b0;
    check("mthi2_hi", hi, 32'h0000_1234);
    m_hi = 32'h0000_1234;
    $display("mthi wdata=00001234 -> hi=%h", hi);
    run_op(2'd1, $urandom, $urandom, 1'b0, 1'b1);

    // Randomized mix
    for (int k = 0; k < 20; k++) begin
      ro = 2'($urandom);
      rx = $urandom;
      ry = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = 32'd0;
      else if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      else if (sel == 2) begin rx = $urandom_range(0, 100); ry = $urandom_range(1, 9); end
      else if (sel == 3) ry = 32'(-$urandom_range(1, 9));
      run_op(ro, rx, ry, 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
